// File: rtl/wb_regfile_pkg.sv
// Shared types for the writeback stage and register file.
// Holds the MEM/WB bundle and writeback select encodings.
package wb_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LD  = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // wb_sel kept as raw bits so the reserved code 3 stays representable
  typedef struct packed {
    logic [1:0]            wb_sel;
    logic                  rd_wren;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       pc4;
    logic [XLEN-1:0]       alu_data;
    logic [XLEN-1:0]       ld_data;
  } MEM_WB_ff;

endpackage

// File: rtl/wb_regfile_mux.sv
// Writeback value select.
// Reserved select code falls back to the ALU result.
module wb_mux
  import wb_regfile_pkg::*;
(
  input  MEM_WB_ff        wb_i,
  output logic [XLEN-1:0] wb_data_o
);

  always_comb begin
    wb_data_o = wb_i.alu_data;
    unique case (1'b1)
      (wb_i.wb_sel == WB_LD):  wb_data_o = wb_i.ld_data;
      (wb_i.wb_sel == WB_PC4): wb_data_o = wb_i.pc4;
      default:                 wb_data_o = wb_i.alu_data;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural register file.
// Two bypassed ID read ports, one raw debug port, write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  MEM_WB_ff              WB_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  input  logic [REG_ADDR_W-1:0] dbg_addr_i,
  output logic [XLEN-1:0]       dbg_data_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic [REG_ADDR_W-1:0] wb_addr_o,
  output logic                  wb_wren_o,
  output logic [31:0]           wr_count_o
);

  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [31:0]     wr_cnt_q;
  logic            addr_ok;

  wb_mux u_mux (
    .wb_i      (WB_i),
    .wb_data_o (wb_data_o)
  );

  assign wb_addr_o = WB_i.rd_addr;
  assign addr_ok   = (WB_i.rd_addr != '0)
                   && (int'(WB_i.rd_addr) < NREGS);
  // reset also masks the write so no bypass leaks out during reset
  assign wb_wren_o = rst_ni & en_i & WB_i.rd_wren & addr_ok;
  assign wr_count_o = wr_cnt_q;

  function automatic logic [XLEN-1:0] stored(
    input logic [REG_ADDR_W-1:0] a
  );
    if (a == '0 || int'(a) >= NREGS) return '0;
    return regs_q[a];
  endfunction

  function automatic logic [XLEN-1:0] rd_port(
    input logic [REG_ADDR_W-1:0] a
  );
    if (BYPASS_EN && wb_wren_o && a == wb_addr_o)
      return wb_data_o;
    return stored(a);
  endfunction

  always_comb begin
    rs1_data_o = rd_port(rs1_addr_i);
    rs2_data_o = rd_port(rs2_addr_i);
    dbg_data_o = stored(dbg_addr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      wr_cnt_q <= '0;
    end else if (wb_wren_o) begin
      regs_q[wb_addr_o] <= wb_data_o;
      wr_cnt_q          <= wr_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile.
// One task per scenario, inline compares.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            en_i;
  MEM_WB_ff        WB_i;
  logic [4:0]      rs1_addr_i, rs2_addr_i, dbg_addr_i;
  logic [31:0]     rs1_data_o, rs2_data_o, dbg_data_o;
  logic [31:0]     wb_data_o;
  logic [4:0]      wb_addr_o;
  logic            wb_wren_o;
  logic [31:0]     wr_count_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  wb_regfile dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .WB_i       (WB_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o),
    .wb_data_o  (wb_data_o),
    .wb_addr_o  (wb_addr_o),
    .wb_wren_o  (wb_wren_o),
    .wr_count_o (wr_count_o)
  );

  task automatic set_wb(
    input logic [1:0]  sel,
    input logic        wren,
    input logic [4:0]  rd,
    input logic [31:0] pc4,
    input logic [31:0] alu,
    input logic [31:0] ld
  );
    WB_i.wb_sel   = sel;
    WB_i.rd_wren  = wren;
    WB_i.rd_addr  = rd;
    WB_i.pc4      = pc4;
    WB_i.alu_data = alu;
    WB_i.ld_data  = ld;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    en_i   = 1'b1;
    set_wb(2'd0, 1'b1, 5'd1, 0, 32'h77, 0);
    rs1_addr_i = 5'd1;
    rs2_addr_i = 5'd1;
    dbg_addr_i = 5'd1;
    repeat (2) @(posedge clk_i);
    #1;
    tests++;
    if (wr_count_o !== 32'd0) begin
      fails++;
      $display("FAIL rst_cnt got %h exp 0", wr_count_o);
    end
    tests++;
    if (wb_wren_o !== 1'b0 || rs1_data_o !== 32'd0) begin
      fails++;
      $display("FAIL rst_bypass wren %b rs1 %h exp 0/0",
               wb_wren_o, rs1_data_o);
    end
    tests++;
    if (wb_data_o !== 32'h77) begin
      fails++;
      $display("FAIL rst_wbdata got %h exp 77", wb_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    set_wb(2'd0, 1'b0, 5'd0, 0, 0, 0);
  endtask

  task automatic test_mux;
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h11;
    exp_v[1] = 32'h22;
    exp_v[2] = 32'h33;
    exp_v[3] = 32'h11;
    dbg_addr_i = 5'd3;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk_i);
      set_wb(2'(s), 1'b1, 5'd3, 32'h33, 32'h11, 32'h22);
      #1;
      tests++;
      if (wb_data_o !== exp_v[s]) begin
        fails++;
        $display("FAIL mux_sel%0d got %h exp %h",
                 s, wb_data_o, exp_v[s]);
      end
      @(posedge clk_i);
      exp_cnt = exp_cnt + 1;
      #1;
      tests++;
      if (dbg_data_o !== exp_v[s]) begin
        fails++;
        $display("FAIL mux_store%0d got %h exp %h",
                 s, dbg_data_o, exp_v[s]);
      end
    end
    tests++;
    if (wr_count_o !== exp_cnt) begin
      fails++;
      $display("FAIL mux_cnt got %h exp %h", wr_count_o, exp_cnt);
    end
  endtask

  task automatic test_x0;
    @(negedge clk_i);
    set_wb(2'd0, 1'b1, 5'd0, 0, 32'hFFFF_FFFF, 0);
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
    dbg_addr_i = 5'd0;
    #1;
    tests++;
    if (wb_wren_o !== 1'b0 || rs1_data_o !== 32'd0) begin
      fails++;
      $display("FAIL x0_bypass wren %b rs1 %h exp 0/0",
               wb_wren_o, rs1_data_o);
    end
    @(posedge clk_i);
    #1;
    tests++;
    if (wr_count_o !== exp_cnt || dbg_data_o !== 32'd0) begin
      fails++;
      $display("FAIL x0_write cnt %h dbg %h exp %h/0",
               wr_count_o, dbg_data_o, exp_cnt);
    end
  endtask

  task automatic test_bypass;
    @(negedge clk_i);
    set_wb(2'd0, 1'b1, 5'd7, 0, 32'hAAAA, 0);
    @(posedge clk_i);
    exp_cnt = exp_cnt + 1;
    @(negedge clk_i);
    set_wb(2'd0, 1'b1, 5'd7, 0, 32'h1234, 0);
    rs1_addr_i = 5'd7;
    rs2_addr_i = 5'd7;
    dbg_addr_i = 5'd7;
    #1;
    tests++;
    if (rs1_data_o !== 32'h1234 || rs2_data_o !== 32'h1234) begin
      fails++;
      $display("FAIL byp_rs rs1 %h rs2 %h exp 1234",
               rs1_data_o, rs2_data_o);
    end
    tests++;
    if (dbg_data_o !== 32'hAAAA) begin
      fails++;
      $display("FAIL byp_dbg_old got %h exp aaaa", dbg_data_o);
    end
    @(posedge clk_i);
    exp_cnt = exp_cnt + 1;
    #1;
    WB_i.rd_wren = 1'b0;
    #1;
    tests++;
    if (dbg_data_o !== 32'h1234 || rs1_data_o !== 32'h1234) begin
      fails++;
      $display("FAIL byp_dbg_new dbg %h rs1 %h exp 1234",
               dbg_data_o, rs1_data_o);
    end
  endtask

  task automatic test_stall;
    @(negedge clk_i);
    en_i = 1'b0;
    set_wb(2'd0, 1'b1, 5'd9, 0, 32'h55, 0);
    rs1_addr_i = 5'd9;
    dbg_addr_i = 5'd9;
    #1;
    tests++;
    if (wb_wren_o !== 1'b0 || rs1_data_o !== 32'd0) begin
      fails++;
      $display("FAIL stall_byp wren %b rs1 %h exp 0/0",
               wb_wren_o, rs1_data_o);
    end
    @(posedge clk_i);
    #1;
    tests++;
    if (dbg_data_o !== 32'd0 || wr_count_o !== exp_cnt) begin
      fails++;
      $display("FAIL stall_hold dbg %h cnt %h exp 0/%h",
               dbg_data_o, wr_count_o, exp_cnt);
    end
    @(negedge clk_i);
    en_i = 1'b1;
    @(posedge clk_i);
    exp_cnt = exp_cnt + 1;
    #1;
    tests++;
    if (dbg_data_o !== 32'h55 || wr_count_o !== exp_cnt) begin
      fails++;
      $display("FAIL stall_release dbg %h cnt %h exp 55/%h",
               dbg_data_o, wr_count_o, exp_cnt);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk_i);
    set_wb(2'd0, 1'b0, 5'd10, 0, 32'h1, 0);
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    #1;
    tests++;
    if (wr_count_o !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL wrap_preload got %h exp ffffffff", wr_count_o);
    end
    WB_i.rd_wren = 1'b1;
    @(posedge clk_i);
    exp_cnt = 32'd0;
    #1;
    tests++;
    if (wr_count_o !== exp_cnt) begin
      fails++;
      $display("FAIL wrap_cnt got %h exp 0", wr_count_o);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    set_wb(2'd0, 1'b1, 5'd5, 0, 32'hDEAD_BEEF, 0);
    @(posedge clk_i);
    exp_cnt = exp_cnt + 1;
    #1;
    rs1_addr_i = 5'd5;
    dbg_addr_i = 5'd5;
    WB_i.rd_wren = 1'b0;
    #1;
    tests++;
    if (dbg_data_o !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL rmid_pre got %h exp deadbeef", dbg_data_o);
    end
    WB_i.rd_wren = 1'b1;
    rst_ni = 1'b0;
    #1;
    exp_cnt = 32'd0;
    tests++;
    if (rs1_data_o !== 32'd0 || wr_count_o !== exp_cnt) begin
      fails++;
      $display("FAIL rmid_async rs1 %h cnt %h exp 0/0",
               rs1_data_o, wr_count_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    set_wb(2'd2, 1'b1, 5'd6, 32'h404, 0, 0);
    dbg_addr_i = 5'd6;
    @(posedge clk_i);
    exp_cnt = exp_cnt + 1;
    #1;
    tests++;
    if (dbg_data_o !== 32'h404 || wr_count_o !== exp_cnt) begin
      fails++;
      $display("FAIL rmid_first dbg %h cnt %h exp 404/%h",
               dbg_data_o, wr_count_o, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_mux();
    test_x0();
    test_bypass();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
